inference_sequencer: RTL and testbench
======================================

INFERENCE_SEQUENCER -- requirements
Module: inference_sequencer

Interface
REQ-001 Parameter layers, default 2, number of sequential dense layers.
REQ-002 Parameter output_rows, default 10, number of classes; label_bits = $clog2(output_rows).
REQ-003 Parameter max_inputs, default 200, number of images per run; cnt_bits = $clog2(max_inputs+1).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_overall  in  1  asynchronous, active-high reset.
REQ-006 upload_done  in  1  one-cycle pulse: weight/data upload complete.
REQ-007 enable_inference  in  1  level: run permitted.
REQ-008 input_loaded  in  1  one-cycle pulse from input loader: image and label valid.
REQ-009 label  in  label_bits  ground-truth class of current image.
REQ-010 layer_done  in  layers  per-layer one-cycle completion pulse.
REQ-011 predicted_class  in  label_bits  argmax of last layer, valid when layer_done[layers-1]=1.
REQ-012 layer_start  out  layers  one-hot one-cycle start pulse.
REQ-013 final_done  out  1  one-cycle pulse: loader advances to next image.
REQ-014 result_valid  out  1  one-cycle pulse: one image classified.
REQ-015 correct_count, infer_count  out  cnt_bits each  run scoreboard.
REQ-016 busy  out  1  high in any state except IDLE and DONE; all_done  out  1  high in DONE.

Function
REQ-017 States SHALL be IDLE, WAIT_LOAD, RUN_LAYER, WAIT_LAYER, COMPARE, NEXT, DONE; all outputs registered (Moore).
REQ-018 upload_done SHALL set a sticky uploaded flag, cleared only by reset.
REQ-019 IDLE -> WAIT_LOAD when enable_inference=1 and uploaded=1 (including same-cycle upload_done); infer_count, correct_count, layer_idx cleared on this transition.
REQ-020 WAIT_LOAD -> RUN_LAYER on input_loaded=1, layer_idx=0; label captured into label_q that cycle.
REQ-021 RUN_LAYER: layer_start[layer_idx]=1 for exactly one cycle, then WAIT_LAYER.
REQ-022 WAIT_LAYER: on layer_done[layer_idx]: if layer_idx=layers-1 capture predicted_class, go COMPARE; else layer_idx+1, go RUN_LAYER; layer_done bits for other indices ignored.
REQ-023 COMPARE: result_valid=1 one cycle; infer_count+1; correct_count+1 iff captured predicted_class=label_q; then DONE if new infer_count=max_inputs else NEXT.
REQ-024 NEXT: final_done=1 one cycle, then WAIT_LOAD.
REQ-025 Latency: input_loaded at edge N -> layer_start[0] high cycle N+1; layer_done[i] at N -> layer_start[i+1] high N+1; last layer_done at N -> result_valid N+1, final_done N+2.
REQ-026 enable_inference=0 in any busy state SHALL return to IDLE next edge, no pulses issued, counters retained.
REQ-027 DONE holds all_done=1 and counters until enable_inference=0, then IDLE.
REQ-028 Counters SHALL never exceed max_inputs; no wrap; correct_count <= infer_count always.
REQ-029 input_loaded outside WAIT_LOAD SHALL be ignored.

Reset
REQ-030 rst_overall=1 SHALL asynchronously force IDLE, uploaded=0, layer_idx=0, label_q=0, all outputs 0, including mid-run.

Structure
REQ-031 Shared package ann_pkg SHALL hold DATAWIDTH=11, INPUT_VECTOR_LENGTH=64, LAYERS, ROWS array {30,10}, OUTPUT_ROWS, MAX_INPUTS, and the sequencer state enum.
REQ-032 One sub-module result_scoreboard SHALL hold infer_count/correct_count with clear, inc, hit inputs.

Verification
REQ-033 Reset then upload_done+enable_inference, input_loaded, layer_done[0], layer_done[1], predicted=label=3 -> layer_start=01 then 10, result_valid once, correct_count=1, infer_count=1, final_done one cycle after result_valid.
REQ-034 predicted=5, label=7 -> infer_count increments, correct_count unchanged.
REQ-035 max_inputs run (200 images, every 4th mismatched) -> all_done=1, infer_count=200, correct_count=150, no final_done after image 200.
REQ-036 layer_done[1] while waiting on layer 0, input_loaded during WAIT_LAYER -> ignored, no state change.
REQ-037 enable_inference dropped in WAIT_LAYER -> IDLE next edge, busy=0, no result_valid; rst_overall mid-run -> immediate all-zero outputs.
REQ-038 enable_inference=1 with no prior upload_done -> stays IDLE, busy=0.

Source files
------------

// File: rtl/ann_pkg.sv
// Shared constants and sequencer state encoding for the ANN inference datapath.
package ann_pkg;

  localparam int unsigned DATAWIDTH           = 11;
  localparam int unsigned INPUT_VECTOR_LENGTH = 64;
  localparam int unsigned LAYERS              = 2;
  localparam int unsigned ROWS [LAYERS]       = '{30, 10};
  localparam int unsigned OUTPUT_ROWS         = ROWS[LAYERS-1];
  localparam int unsigned MAX_INPUTS          = 200;

  typedef enum logic [2:0] {
    StIdle,
    StWaitLoad,
    StRunLayer,
    StWaitLayer,
    StCompare,
    StNext,
    StDone
  } seq_state_e;

endpackage

// File: rtl/result_scoreboard.sv
// Run scoreboard: counts classified images and correct classifications.
module result_scoreboard #(
  parameter int unsigned max_count = 200,
  parameter int unsigned cnt_bits  = $clog2(max_count + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                inc,
  input  logic                hit,
  output logic [cnt_bits-1:0] infer_count,
  output logic [cnt_bits-1:0] correct_count
);

  localparam logic [cnt_bits-1:0] MaxCount = cnt_bits'(max_count);

  // Saturating counters; correct_count only moves together with infer_count so it never leads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      infer_count   <= '0;
      correct_count <= '0;
    end else if (clear) begin
      infer_count   <= '0;
      correct_count <= '0;
    end else if (inc && (infer_count != MaxCount)) begin
      infer_count <= infer_count + cnt_bits'(1);
      if (hit) begin
        correct_count <= correct_count + cnt_bits'(1);
      end
    end
  end

endmodule

// File: rtl/inference_sequencer.sv
// Sequences dense layers per image, scores the prediction and advances the input loader.
module inference_sequencer
  import ann_pkg::*;
#(
  parameter int unsigned layers      = LAYERS,
  parameter int unsigned output_rows = OUTPUT_ROWS,
  parameter int unsigned max_inputs  = MAX_INPUTS,
  parameter int unsigned label_bits  = $clog2(output_rows),
  parameter int unsigned cnt_bits    = $clog2(max_inputs + 1)
) (
  input  logic                  clk,
  input  logic                  rst_overall,
  input  logic                  upload_done,
  input  logic                  enable_inference,
  input  logic                  input_loaded,
  input  logic [label_bits-1:0] label,
  input  logic [layers-1:0]     layer_done,
  input  logic [label_bits-1:0] predicted_class,
  output logic [layers-1:0]     layer_start,
  output logic                  final_done,
  output logic                  result_valid,
  output logic [cnt_bits-1:0]   correct_count,
  output logic [cnt_bits-1:0]   infer_count,
  output logic                  busy,
  output logic                  all_done
);

  localparam int unsigned idx_bits = (layers > 1) ? $clog2(layers) : 1;
  localparam logic [idx_bits-1:0] LastIdx  = idx_bits'(layers - 1);
  localparam logic [cnt_bits-1:0] MaxCount = cnt_bits'(max_inputs);
  localparam logic [layers-1:0]   OneHot0  = layers'(1);

  seq_state_e            state_q, state_d;
  logic [idx_bits-1:0]   idx_q, idx_d;
  logic [label_bits-1:0] label_q;
  logic                  uploaded_q;
  logic                  sb_clear, sb_inc, sb_hit;
  logic                  state_busy;
  logic [layers-1:0]     start_d;

  result_scoreboard #(
    .max_count (max_inputs),
    .cnt_bits  (cnt_bits)
  ) u_scoreboard (
    .clk           (clk),
    .rst           (rst_overall),
    .clear         (sb_clear),
    .inc           (sb_inc),
    .hit           (sb_hit),
    .infer_count   (infer_count),
    .correct_count (correct_count)
  );

  // Next-state, layer index and scoreboard controls.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    sb_clear   = 1'b0;
    sb_inc     = 1'b0;
    sb_hit     = 1'b0;
    state_busy = (state_q != StIdle) && (state_q != StDone);
    unique case (state_q)
      StIdle: begin
        if (enable_inference && (uploaded_q || upload_done)) begin
          state_d  = StWaitLoad;
          idx_d    = '0;
          sb_clear = 1'b1;
        end
      end
      StWaitLoad: begin
        if (input_loaded) begin
          state_d = StRunLayer;
          idx_d   = '0;
        end
      end
      StRunLayer: state_d = StWaitLayer;
      StWaitLayer: begin
        if (layer_done[idx_q]) begin
          if (idx_q == LastIdx) begin
            // Prediction is scored on the edge it is valid, so counters line up with result_valid.
            state_d = StCompare;
            sb_inc  = 1'b1;
            sb_hit  = (predicted_class == label_q);
          end else begin
            state_d = StRunLayer;
            idx_d   = idx_q + idx_bits'(1);
          end
        end
      end
      StCompare: state_d = (infer_count == MaxCount) ? StDone : StNext;
      StNext:    state_d = StWaitLoad;
      StDone: begin
        if (!enable_inference) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Dropping enable aborts the run without scoring or pulsing anything.
    if (state_busy && !enable_inference) begin
      state_d = StIdle;
      sb_inc  = 1'b0;
      sb_hit  = 1'b0;
    end
    start_d = (state_d == StRunLayer) ? (OneHot0 << idx_d) : '0;
  end

  // State, captured label, sticky upload flag and registered (Moore) outputs.
  always_ff @(posedge clk or posedge rst_overall) begin
    if (rst_overall) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      label_q      <= '0;
      uploaded_q   <= 1'b0;
      layer_start  <= '0;
      result_valid <= 1'b0;
      final_done   <= 1'b0;
      busy         <= 1'b0;
      all_done     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      uploaded_q <= uploaded_q | upload_done;
      if ((state_q == StWaitLoad) && (state_d == StRunLayer)) begin
        label_q <= label;
      end
      layer_start  <= start_d;
      result_valid <= (state_d == StCompare);
      final_done   <= (state_d == StNext);
      busy         <= (state_d != StIdle) && (state_d != StDone);
      all_done     <= (state_d == StDone);
    end
  end

endmodule

// File: tb/tb_inference_sequencer.sv
// Directed-sequence bench with randomized labels/predictions and a counting reference model.
module tb_inference_sequencer;

  localparam int unsigned Layers    = 2;
  localparam int unsigned Rows      = 10;
  localparam int unsigned MaxIn     = 200;
  localparam int unsigned LabelBits = 4;
  localparam int unsigned CntBits   = 8;

  logic                 clk = 1'b0;
  logic                 rst_overall;
  logic                 upload_done;
  logic                 enable_inference;
  logic                 input_loaded;
  logic [LabelBits-1:0] label;
  logic [Layers-1:0]    layer_done;
  logic [LabelBits-1:0] predicted_class;
  logic [Layers-1:0]    layer_start;
  logic                 final_done;
  logic                 result_valid;
  logic [CntBits-1:0]   correct_count;
  logic [CntBits-1:0]   infer_count;
  logic                 busy;
  logic                 all_done;

  int n_cmp = 0;
  int n_err = 0;
  int exp_infer = 0;
  int exp_correct = 0;

  inference_sequencer #(
    .layers      (Layers),
    .output_rows (Rows),
    .max_inputs  (MaxIn)
  ) dut (
    .clk              (clk),
    .rst_overall      (rst_overall),
    .upload_done      (upload_done),
    .enable_inference (enable_inference),
    .input_loaded     (input_loaded),
    .label            (label),
    .layer_done       (layer_done),
    .predicted_class  (predicted_class),
    .layer_start      (layer_start),
    .final_done       (final_done),
    .result_valid     (result_valid),
    .correct_count    (correct_count),
    .infer_count      (infer_count),
    .busy             (busy),
    .all_done         (all_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_start"}, {30'd0, layer_start}, 0);
    check({tag, "_fd"}, {31'd0, final_done}, 0);
    check({tag, "_rv"}, {31'd0, result_valid}, 0);
    check({tag, "_busy"}, {31'd0, busy}, 0);
    check({tag, "_alldone"}, {31'd0, all_done}, 0);
    check({tag, "_infer"}, {24'd0, infer_count}, 0);
    check({tag, "_correct"}, {24'd0, correct_count}, 0);
  endtask

  // One full image from WAIT_LOAD; the model counts results and predicts pulse timing.
  task automatic run_image(input int lbl, input int pred, input bit glitch);
    label        = lbl[LabelBits-1:0];
    input_loaded = 1'b1;
    tick();
    input_loaded = 1'b0;
    label        = LabelBits'($urandom_range(0, Rows - 1));
    check("start_l0", {30'd0, layer_start}, 32'd1);
    check("busy_run", {31'd0, busy}, 1);
    tick();
    check("start_l0_once", {30'd0, layer_start}, 0);
    if (glitch) begin
      layer_done   = 2'b10;
      input_loaded = 1'b1;
      tick();
      layer_done   = 2'b00;
      input_loaded = 1'b0;
      check("stray_start", {30'd0, layer_start}, 0);
      check("stray_rv", {31'd0, result_valid}, 0);
      check("stray_busy", {31'd0, busy}, 1);
    end
    layer_done = 2'b01;
    tick();
    layer_done = 2'b00;
    check("start_l1", {30'd0, layer_start}, 32'd2);
    tick();
    check("start_l1_once", {30'd0, layer_start}, 0);
    check("rv_early", {31'd0, result_valid}, 0);
    layer_done      = 2'b10;
    predicted_class = pred[LabelBits-1:0];
    tick();
    layer_done      = 2'b00;
    predicted_class = LabelBits'($urandom_range(0, Rows - 1));
    exp_infer++;
    if (lbl == pred) exp_correct++;
    check("rv_pulse", {31'd0, result_valid}, 1);
    check("infer_cnt", {24'd0, infer_count}, exp_infer);
    check("correct_cnt", {24'd0, correct_count}, exp_correct);
    check("fd_with_rv", {31'd0, final_done}, 0);
    tick();
    check("rv_once", {31'd0, result_valid}, 0);
    if (exp_infer == MaxIn) begin
      check("done_alldone", {31'd0, all_done}, 1);
      check("done_busy", {31'd0, busy}, 0);
      check("done_no_fd", {31'd0, final_done}, 0);
    end else begin
      check("fd_pulse", {31'd0, final_done}, 1);
      tick();
      check("fd_once", {31'd0, final_done}, 0);
      check("busy_waitload", {31'd0, busy}, 1);
    end
  endtask

  initial begin
    int lbl;
    int pred;
    rst_overall      = 1'b1;
    upload_done      = 1'b0;
    enable_inference = 1'b0;
    input_loaded     = 1'b0;
    label            = '0;
    layer_done       = '0;
    predicted_class  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_overall = 1'b0;

    // Enable without any upload: must stay idle.
    enable_inference = 1'b1;
    repeat (3) tick();
    check("no_upload_busy", {31'd0, busy}, 0);
    check("no_upload_alldone", {31'd0, all_done}, 0);

    // Upload pulse in the same cycle as enable starts the run.
    upload_done = 1'b1;
    tick();
    upload_done = 1'b0;
    check("start_busy", {31'd0, busy}, 1);
    check("start_infer", {24'd0, infer_count}, 0);

    run_image(3, 3, 1'b0);
    check("hit_correct", {24'd0, correct_count}, 1);
    run_image(7, 5, 1'b1);
    check("miss_infer", {24'd0, infer_count}, 2);
    check("miss_correct", {24'd0, correct_count}, 1);

    // Abort in WAIT_LAYER of the last layer while its done pulse arrives.
    label        = 4'd2;
    input_loaded = 1'b1;
    tick();
    input_loaded = 1'b0;
    tick();
    layer_done = 2'b01;
    tick();
    layer_done = 2'b00;
    tick();
    enable_inference = 1'b0;
    layer_done       = 2'b10;
    predicted_class  = 4'd2;
    tick();
    layer_done = 2'b00;
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_rv", {31'd0, result_valid}, 0);
    check("abort_start", {30'd0, layer_start}, 0);
    check("abort_infer", {24'd0, infer_count}, 2);
    check("abort_correct", {24'd0, correct_count}, 1);
    tick();
    check("abort_rv_later", {31'd0, result_valid}, 0);
    check("abort_fd_later", {31'd0, final_done}, 0);

    // Fresh full-length run: counters clear on start.
    enable_inference = 1'b1;
    tick();
    exp_infer   = 0;
    exp_correct = 0;
    check("rerun_busy", {31'd0, busy}, 1);
    check("rerun_infer_clr", {24'd0, infer_count}, 0);
    check("rerun_correct_clr", {24'd0, correct_count}, 0);
    for (int i = 0; i < int'(MaxIn); i++) begin
      lbl = int'($urandom_range(0, Rows - 1));
      if (i % 4 == 3) pred = (lbl + 1 + int'($urandom_range(0, Rows - 2))) % Rows;
      else pred = lbl;
      run_image(lbl, pred, (i % 7) == 0);
    end
    repeat (3) tick();
    check("hold_alldone", {31'd0, all_done}, 1);
    check("hold_infer", {24'd0, infer_count}, MaxIn);
    check("hold_correct", {24'd0, correct_count}, 150);
    check("hold_correct_model", {24'd0, correct_count}, exp_correct);
    check("hold_no_fd", {31'd0, final_done}, 0);

    // Leaving DONE keeps the scoreboard.
    enable_inference = 1'b0;
    tick();
    check("exit_alldone", {31'd0, all_done}, 0);
    check("exit_busy", {31'd0, busy}, 0);
    check("exit_infer", {24'd0, infer_count}, MaxIn);
    check("exit_correct", {24'd0, correct_count}, 150);

    // Restart (upload still sticky), then reset mid-pulse.
    enable_inference = 1'b1;
    tick();
    check("restart_busy", {31'd0, busy}, 1);
    check("restart_infer", {24'd0, infer_count}, 0);
    label        = 4'd4;
    input_loaded = 1'b1;
    tick();
    input_loaded = 1'b0;
    check("prereset_start", {30'd0, layer_start}, 32'd1);
    #2 rst_overall = 1'b1;
    #1 check_all_zero("async_reset");
    #1 rst_overall = 1'b0;

    // Reset also cleared the upload flag.
    repeat (3) tick();
    check("post_reset_busy", {31'd0, busy}, 0);
    check("post_reset_start", {30'd0, layer_start}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
